// File: rtl/flow_ctrl_pkg.sv
// flow_ctrl_pkg: shared register width and FSM state encodings for the flow controller
package flow_ctrl_pkg;
   localparam int REG_W = 32;
   typedef logic [REG_W-1:0] reg_t;
   typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} fc_state_e;
endpackage

// File: rtl/flow_ctrl_redirect_buf.sv
// redirect_buf: one-entry pending redirect; a pending trap is never displaced by a jump
module redirect_buf import flow_ctrl_pkg::*; (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic cap,
   input  logic trap_en,
   input  reg_t trap_addr,
   input  logic jump_en,
   input  reg_t jump_addr,
   output logic pend_valid,
   output reg_t pend_addr
);
   logic pend_trap;
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_valid <= 1'b0;
         pend_trap  <= 1'b0;
         pend_addr  <= '0;
      end else if (clr) begin
         pend_valid <= 1'b0;
         pend_trap  <= 1'b0;
      end else if (cap && trap_en) begin
         pend_valid <= 1'b1;
         pend_trap  <= 1'b1;
         pend_addr  <= trap_addr;
      end else if (cap && jump_en && !(pend_valid && pend_trap)) begin
         pend_valid <= 1'b1;
         pend_trap  <= 1'b0;
         pend_addr  <= jump_addr;
      end
   end
endmodule

// File: rtl/flow_ctrl.sv
// flow_ctrl: PC redirect arbitration, stall/flush generation and debug halt sequencing
module flow_ctrl import flow_ctrl_pkg::*; #(
   parameter int DRAIN_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic jtag_reset,
   input  logic ex_jump_en,
   input  reg_t ex_jump_addr,
   input  logic trap_en,
   input  reg_t trap_addr,
   input  logic hold_req,
   input  logic bus_busy,
   input  logic dbg_halt_req,
   input  logic dbg_resume_req,
   output logic jump_en,
   output reg_t jump_addr,
   output logic halt,
   output logic flush,
   output logic dbg_halted,
   output logic drain_timeout
);
   localparam int CW = $clog2(DRAIN_TIMEOUT) + 1;
   fc_state_e state, state_nxt;
   logic [CW-1:0] cnt;
   logic rst_any, cnt_last, pend_valid;
   reg_t pend_addr;
   assign rst_any  = rst | jtag_reset;
   assign cnt_last = cnt == CW'(DRAIN_TIMEOUT - 1);
   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     state_nxt = dbg_halt_req ? DRAIN : RUN;
         DRAIN:   state_nxt = (!bus_busy || cnt_last) ? HALTED : DRAIN;
         HALTED:  state_nxt = (dbg_resume_req && !dbg_halt_req) ? RUN : HALTED;
         default: state_nxt = RUN;
      endcase
   end
   // live redirects only leave the core in RUN; pending entries wait for resume
   assign jump_en   = !rst_any && state == RUN && (trap_en || ex_jump_en || pend_valid);
   assign jump_addr = !jump_en ? '0 : trap_en ? trap_addr : ex_jump_en ? ex_jump_addr : pend_addr;
   assign flush     = jump_en;
   assign halt      = rst_any ? hold_req : (state != RUN) || (hold_req && !jump_en);
   always_ff @(posedge clk) begin
      if (rst_any) begin
         state         <= RUN;
         cnt           <= '0;
         drain_timeout <= 1'b0;
         dbg_halted    <= 1'b0;
      end else begin
         state      <= state_nxt;
         dbg_halted <= state_nxt == HALTED;
         cnt        <= (state == RUN && dbg_halt_req) ? '0 :
                       (state == DRAIN && !(&cnt)) ? cnt + 1'b1 : cnt;
         if (state == DRAIN && state_nxt == HALTED)
            drain_timeout <= bus_busy;
      end
   end
   redirect_buf u_buf (
      .clk        (clk),
      .rst        (rst_any),
      .clr        (state == RUN),
      .cap        (state != RUN),
      .trap_en    (trap_en),
      .trap_addr  (trap_addr),
      .jump_en    (ex_jump_en),
      .jump_addr  (ex_jump_addr),
      .pend_valid (pend_valid),
      .pend_addr  (pend_addr)
   );
endmodule

// File: tb/tb_flow_ctrl.sv
// tb_flow_ctrl: directed scenarios plus randomized traffic against a behavioural model
module tb_flow_ctrl;
   localparam int TO = 4;
   localparam int M_RUN = 0, M_DRAIN = 1, M_HALT = 2;
   logic clk = 1'b0;
   logic rst = 1'b1, jtag_reset = 1'b0, ex_jump_en = 1'b0, trap_en = 1'b0;
   logic hold_req = 1'b0, bus_busy = 1'b0, dbg_halt_req = 1'b0, dbg_resume_req = 1'b0;
   logic [31:0] ex_jump_addr = '0, trap_addr = '0, jump_addr;
   logic jump_en, halt, flush, dbg_halted, drain_timeout;
   int n_vec = 0, n_err = 0;
   int m_st = M_RUN, m_cnt = 0;
   bit pv = 0, pt = 0, m_to = 0, m_dh = 0;
   logic [31:0] pa = '0;

   always #5 clk = ~clk;

   flow_ctrl #(.DRAIN_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .jtag_reset(jtag_reset),
      .ex_jump_en(ex_jump_en), .ex_jump_addr(ex_jump_addr),
      .trap_en(trap_en), .trap_addr(trap_addr),
      .hold_req(hold_req), .bus_busy(bus_busy),
      .dbg_halt_req(dbg_halt_req), .dbg_resume_req(dbg_resume_req),
      .jump_en(jump_en), .jump_addr(jump_addr), .halt(halt), .flush(flush),
      .dbg_halted(dbg_halted), .drain_timeout(drain_timeout)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_update(input bit rs);
      int nxt;
      if (rs) begin
         m_st = M_RUN; m_cnt = 0; pv = 0; pt = 0; pa = '0; m_to = 0; m_dh = 0;
      end else begin
         nxt = m_st;
         if (m_st == M_RUN) begin
            if (dbg_halt_req) begin nxt = M_DRAIN; m_cnt = 0; end
            pv = 0;
         end else begin
            if (trap_en) begin pv = 1; pt = 1; pa = trap_addr; end
            else if (ex_jump_en && !(pv && pt)) begin pv = 1; pt = 0; pa = ex_jump_addr; end
            if (m_st == M_DRAIN) begin
               if (!bus_busy) begin nxt = M_HALT; m_to = 0; end
               else if (m_cnt == TO - 1) begin nxt = M_HALT; m_to = 1; end
               m_cnt++;
            end else if (dbg_resume_req && !dbg_halt_req) nxt = M_RUN;
         end
         m_st = nxt;
         m_dh = (nxt == M_HALT);
      end
   endtask

   task automatic step();
      bit rs, je, eh;
      logic [31:0] ja;
      @(negedge clk);
      rs = rst || jtag_reset;
      je = !rs && m_st == M_RUN && (trap_en || ex_jump_en || pv);
      ja = !je ? 32'h0 : trap_en ? trap_addr : ex_jump_en ? ex_jump_addr : pa;
      eh = rs ? hold_req : (m_st != M_RUN) || (hold_req && !je);
      chk("jump_en", 32'(jump_en), 32'(je));
      chk("jump_addr", jump_addr, ja);
      chk("flush", 32'(flush), 32'(je));
      chk("halt", 32'(halt), 32'(eh));
      chk("dbg_halted", 32'(dbg_halted), 32'(m_dh));
      chk("drain_timeout", 32'(drain_timeout), 32'(m_to));
      @(posedge clk);
      model_update(rs);
      #1;
   endtask

   task automatic clr_in();
      ex_jump_en = 0; trap_en = 0; hold_req = 0; bus_busy = 0;
      dbg_halt_req = 0; dbg_resume_req = 0; rst = 0; jtag_reset = 0;
   endtask

   initial begin
      bit hr;
      repeat (2) @(posedge clk);
      #1;
      trap_en = 1; trap_addr = 32'h40; hold_req = 1;
      #1;
      chk("rst_jump_en", 32'(jump_en), 32'h0);
      chk("rst_jump_addr", jump_addr, 32'h0);
      chk("rst_halt", 32'(halt), 32'h1);
      chk("rst_dbg_halted", 32'(dbg_halted), 32'h0);
      chk("rst_timeout", 32'(drain_timeout), 32'h0);
      step();
      clr_in();
      // trap beats a same-cycle jump
      trap_en = 1; trap_addr = 32'h40; ex_jump_en = 1; ex_jump_addr = 32'h100;
      #1;
      chk("s1_jump_en", 32'(jump_en), 32'h1);
      chk("s1_jump_addr", jump_addr, 32'h40);
      chk("s1_flush", 32'(flush), 32'h1);
      step();
      clr_in();
      hold_req = 1; ex_jump_en = 1; ex_jump_addr = 32'h20;
      #1;
      chk("s5_halt_redirect", 32'(halt), 32'h0);
      chk("s5_jump_en", 32'(jump_en), 32'h1);
      step();
      ex_jump_en = 0;
      #1;
      chk("s5_halt_hold", 32'(halt), 32'h1);
      chk("s5_no_jump", 32'(jump_en), 32'h0);
      step();
      clr_in();
      // bus drains on the fourth DRAIN cycle
      dbg_halt_req = 1; bus_busy = 1;
      step();
      repeat (3) begin
         #1;
         chk("s2_draining", 32'(dbg_halted), 32'h0);
         step();
      end
      bus_busy = 0;
      step();
      #1;
      chk("s2_dbg_halted", 32'(dbg_halted), 32'h1);
      chk("s2_halt", 32'(halt), 32'h1);
      chk("s2_timeout", 32'(drain_timeout), 32'h0);
      dbg_halt_req = 0; dbg_resume_req = 1;
      step();
      clr_in();
      #1;
      chk("s2_resumed", 32'(dbg_halted), 32'h0);
      // bus never drains: forced halt after TO cycles
      dbg_halt_req = 1; bus_busy = 1;
      step();
      for (int i = 0; i < TO; i++) begin
         #1;
         chk("s3_draining", 32'(dbg_halted), 32'h0);
         step();
      end
      #1;
      chk("s3_dbg_halted", 32'(dbg_halted), 32'h1);
      chk("s3_timeout", 32'(drain_timeout), 32'h1);
      ex_jump_en = 1; ex_jump_addr = 32'h200;
      #1;
      chk("s4_no_jump_halted", 32'(jump_en), 32'h0);
      step();
      ex_jump_en = 0; trap_en = 1; trap_addr = 32'h80;
      step();
      trap_en = 0; ex_jump_en = 1; ex_jump_addr = 32'h300;
      step();
      ex_jump_en = 0; dbg_halt_req = 0; dbg_resume_req = 1;
      step();
      clr_in();
      #1;
      chk("s4_jump_en", 32'(jump_en), 32'h1);
      chk("s4_jump_addr", jump_addr, 32'h80);
      step();
      #1;
      chk("s4_pend_cleared", 32'(jump_en), 32'h0);
      // jtag reset while halted with a pending redirect
      dbg_halt_req = 1;
      step();
      step();
      ex_jump_en = 1; ex_jump_addr = 32'h44;
      step();
      ex_jump_en = 0; dbg_halt_req = 0; jtag_reset = 1;
      #1;
      chk("s6_jump_in_reset", 32'(jump_en), 32'h0);
      step();
      jtag_reset = 0;
      #1;
      chk("s6_dbg_halted", 32'(dbg_halted), 32'h0);
      chk("s6_running", 32'(halt), 32'h0);
      chk("s6_no_redirect", 32'(jump_en), 32'h0);
      step();
      hr = 0;
      for (int i = 0; i < 3000; i++) begin
         rst = $urandom_range(0, 99) == 0;
         jtag_reset = $urandom_range(0, 149) == 0;
         trap_en = $urandom_range(0, 7) == 0;
         ex_jump_en = $urandom_range(0, 3) == 0;
         trap_addr = $urandom;
         ex_jump_addr = $urandom;
         hold_req = $urandom_range(0, 3) == 0;
         bus_busy = $urandom_range(0, 3) != 0;
         if ($urandom_range(0, 9) == 0) hr = ~hr;
         dbg_halt_req = hr;
         dbg_resume_req = $urandom_range(0, 5) == 0;
         step();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
